// File: rtl/ipbus_arb_pkg.sv
//============================================================================
// Module      : ipbus_arb_pkg
// Description : Shared FSM state and grant encodings for the two-master
//               IP access bus arbiter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package ipbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic [1:0] gnt_onehot(input logic idx);
        return idx ? GNT_M1 : GNT_M0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ipbus_arbiter_rr_arb2.sv
//============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin picker with lock override.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_arb2
    import ipbus_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       lock_valid_i,
    input  logic       lock_owner_i,
    output logic [1:0] winner_o
);

    always_comb begin
        winner_o = GNT_NONE;
        if (lock_valid_i) begin
            // A live lock excludes the other master even when it is requesting.
            if (req_i[lock_owner_i]) begin
                winner_o = gnt_onehot(lock_owner_i);
            end
        end else begin
            case (req_i)
                2'b01:   winner_o = GNT_M0;
                2'b10:   winner_o = GNT_M1;
                2'b11:   winner_o = last_grant_i ? GNT_M0 : GNT_M1;
                default: winner_o = GNT_NONE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ipbus_arbiter.sv
//============================================================================
// Module      : ipbus_arbiter
// Description : Two-master round-robin arbiter for the IP access bus with a
//               fixed-length access window and registered read return.
//               Optional grant locking enabled by IPBUS_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ipbus_arbiter
    import ipbus_arb_pkg::*;
#(
    parameter int ACC_CYC = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          bus2ip_clk,
    input  logic          bus2ip_rst_n,

    input  logic          m0_req_i,
    input  logic          m0_write_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic          m0_lock_i,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m0_ack_o,

    input  logic          m1_req_i,
    input  logic          m1_write_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic          m1_lock_i,
    output logic [DW-1:0] m1_rdata_o,
    output logic          m1_ack_o,

    output logic [AW-1:0] ip_addr_o,
    output logic [DW-1:0] ip_wdata_o,
    output logic          ip_rd_ce_o,
    output logic          ip_wr_ce_o,
    input  logic [DW-1:0] ip_rdata_i,

    output logic [1:0]    grant_o
);

    localparam int               CNT_W    = $clog2(ACC_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       grant_q;
    logic             last_grant_q;
    logic             write_q;
    logic [AW-1:0]    ip_addr_q;
    logic [DW-1:0]    ip_wdata_q;
    logic             rd_ce_q;
    logic             wr_ce_q;
    logic [DW-1:0]    m0_rdata_q;
    logic [DW-1:0]    m1_rdata_q;
    logic             m0_ack_q;
    logic             m1_ack_q;

    logic [1:0]       w_winner;
    logic             w_sel_m1;
    logic             w_lock_valid;
    logic             w_lock_owner;

`ifdef IPBUS_ARB_LOCK_EN
    logic             lock_q;
    logic             lock_owner_q;
    logic             w_owner_lock;

    assign w_owner_lock = lock_owner_q ? m1_lock_i : m0_lock_i;
    // The lock only binds while its owner keeps lock_i high.
    assign w_lock_valid = lock_q && w_owner_lock;
    assign w_lock_owner = lock_owner_q;
`else
    logic             w_unused_lock;

    assign w_unused_lock = m0_lock_i ^ m1_lock_i;
    assign w_lock_valid  = 1'b0;
    assign w_lock_owner  = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_grant_i (last_grant_q),
        .lock_valid_i (w_lock_valid),
        .lock_owner_i (w_lock_owner),
        .winner_o     (w_winner)
    );

    assign w_sel_m1 = w_winner[1];

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= GNT_NONE;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            ip_addr_q    <= '0;
            ip_wdata_q   <= '0;
            rd_ce_q      <= 1'b0;
            wr_ce_q      <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
`ifdef IPBUS_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef IPBUS_ARB_LOCK_EN
                    if (lock_q && !w_owner_lock) begin
                        lock_q <= 1'b0;
                    end
`endif
                    if (w_winner != GNT_NONE) begin
                        grant_q    <= w_winner;
                        write_q    <= w_sel_m1 ? m1_write_i : m0_write_i;
                        ip_addr_q  <= w_sel_m1 ? m1_addr_i  : m0_addr_i;
                        ip_wdata_q <= w_sel_m1 ? m1_wdata_i : m0_wdata_i;
                        rd_ce_q    <= w_sel_m1 ? !m1_write_i : !m0_write_i;
                        wr_ce_q    <= w_sel_m1 ? m1_write_i  : m0_write_i;
                        cnt_q      <= CNT_LOAD;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    wr_ce_q <= 1'b0;
                    if (cnt_q == '0) begin
                        rd_ce_q <= 1'b0;
                        if (!write_q) begin
                            if (grant_q[1]) begin
                                m1_rdata_q <= ip_rdata_i;
                            end else begin
                                m0_rdata_q <= ip_rdata_i;
                            end
                        end
                        m0_ack_q <= grant_q[0];
                        m1_ack_q <= grant_q[1];
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    last_grant_q <= grant_q[1];
                    grant_q      <= GNT_NONE;
`ifdef IPBUS_ARB_LOCK_EN
                    if (grant_q[1] ? m1_lock_i : m0_lock_i) begin
                        lock_q       <= 1'b1;
                        lock_owner_q <= grant_q[1];
                    end
`endif
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
    assign m0_ack_o   = m0_ack_q;
    assign m1_ack_o   = m1_ack_q;
    assign ip_addr_o  = ip_addr_q;
    assign ip_wdata_o = ip_wdata_q;
    assign ip_rd_ce_o = rd_ce_q;
    assign ip_wr_ce_o = wr_ce_q;
    assign grant_o    = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_ipbus_arbiter.sv
//============================================================================
// Module      : tb_ipbus_arbiter
// Description : Directed self-checking bench for ipbus_arbiter (ACC_CYC=2).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ipbus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_write, m0_lock;
    logic [15:0] m0_addr, m0_wdata;
    logic [15:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req, m1_write, m1_lock;
    logic [15:0] m1_addr, m1_wdata;
    logic [15:0] m1_rdata;
    logic        m1_ack;
    logic [15:0] ip_addr, ip_wdata, ip_rdata;
    logic        ip_rd_ce, ip_wr_ce;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_errors = 0;

    ipbus_arbiter #(.ACC_CYC(2), .AW(16), .DW(16)) dut (
        .bus2ip_clk   (clk),
        .bus2ip_rst_n (rst_n),
        .m0_req_i     (m0_req),
        .m0_write_i   (m0_write),
        .m0_addr_i    (m0_addr),
        .m0_wdata_i   (m0_wdata),
        .m0_lock_i    (m0_lock),
        .m0_rdata_o   (m0_rdata),
        .m0_ack_o     (m0_ack),
        .m1_req_i     (m1_req),
        .m1_write_i   (m1_write),
        .m1_addr_i    (m1_addr),
        .m1_wdata_i   (m1_wdata),
        .m1_lock_i    (m1_lock),
        .m1_rdata_o   (m1_rdata),
        .m1_ack_o     (m1_ack),
        .ip_addr_o    (ip_addr),
        .ip_wdata_o   (ip_wdata),
        .ip_rd_ce_o   (ip_rd_ce),
        .ip_wr_ce_o   (ip_wr_ce),
        .ip_rdata_i   (ip_rdata),
        .grant_o      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One read transfer from IDLE: grant, two ce cycles, ack, back to IDLE.
    task automatic xfer(input string tag, input logic [1:0] exp_gnt,
                        input logic [15:0] exp_addr, input logic [15:0] rd);
        ip_rdata = rd;
        step();
        chk_eq({tag, " grant"}, 32'(grant), 32'(exp_gnt));
        chk_eq({tag, " addr"}, 32'(ip_addr), 32'(exp_addr));
        chk_eq({tag, " rd_ce c1"}, 32'(ip_rd_ce), 32'd1);
        step();
        chk_eq({tag, " rd_ce c2"}, 32'(ip_rd_ce), 32'd1);
        step();
        chk_eq({tag, " ack"}, 32'({m1_ack, m0_ack}), 32'(exp_gnt));
        chk_eq({tag, " ce in ack"}, 32'({ip_wr_ce, ip_rd_ce}), 32'd0);
        chk_eq({tag, " rdata"}, 32'(exp_gnt[1] ? m1_rdata : m0_rdata), 32'(rd));
        step();
        chk_eq({tag, " idle grant/ack"}, 32'({grant, m1_ack, m0_ack}), 32'd0);
    endtask

    logic [1:0] lock_seq [4];

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_write = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_write = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        ip_rdata = '0;
        repeat (2) step();
        chk_eq("reset outputs", 32'({grant, m0_ack, m1_ack, ip_rd_ce, ip_wr_ce}), 32'd0);
        chk_eq("reset rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        #4 rst_n = 1'b1;
        step();

        // Single read by m0
        m0_req = 1; m0_write = 0; m0_addr = 16'h0040;
        xfer("read m0", 2'b01, 16'h0040, 16'hBEEF);
        m0_req = 0;

        // Single write by m1; slave data must not leak into m1_rdata
        m1_req = 1; m1_write = 1; m1_addr = 16'h0008; m1_wdata = 16'h1234;
        ip_rdata = 16'hDEAD;
        step();
        chk_eq("wr grant", 32'(grant), 32'h2);
        chk_eq("wr ce c1", 32'({ip_wr_ce, ip_rd_ce}), 32'h2);
        chk_eq("wr addr/data", {ip_addr, ip_wdata}, 32'h0008_1234);
        step();
        chk_eq("wr ce c2", 32'({ip_wr_ce, ip_rd_ce}), 32'h0);
        step();
        chk_eq("wr ack", 32'({m1_ack, m0_ack}), 32'h2);
        chk_eq("wr rdata kept", 32'(m1_rdata), 32'h0);
        m1_req = 0; m1_write = 0;
        step();
        chk_eq("wr idle", 32'({grant, m1_ack}), 32'h0);

        // Both masters continuously requesting: strict alternation, m0 first
        m0_req = 1; m0_addr = 16'h0100;
        m1_req = 1; m1_addr = 16'h0200;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) xfer($sformatf("rr%0d", i), 2'b01, 16'h0100, 16'hA000 + 16'(i));
            else            xfer($sformatf("rr%0d", i), 2'b10, 16'h0200, 16'hA000 + 16'(i));
        end
        m1_req = 0;

        // m0 alone, so last_grant=m0 and the next tie goes to m1
        xfer("solo m0", 2'b01, 16'h0100, 16'h5555);
        m1_req = 1;
        step();
        chk_eq("pre-reset grant", 32'(grant), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async rst grant/ce", 32'({grant, ip_rd_ce, ip_wr_ce}), 32'h0);
        chk_eq("async rst addr", 32'(ip_addr), 32'h0);
        chk_eq("async rst rdata", 32'(m0_rdata), 32'h0);
        step();
        chk_eq("rst no ack", 32'({m1_ack, m0_ack}), 32'h0);
        #3 rst_n = 1'b1;
        step();
        chk_eq("post-rst tie m0", 32'(grant), 32'h1);
        m0_req = 0; m1_req = 0;
        repeat (3) step();
        chk_eq("post-rst done", 32'(grant), 32'h0);

        // Request dropped during ACCESS still completes exactly once
        m0_req = 1; ip_rdata = 16'h7777;
        step();
        chk_eq("drop grant", 32'(grant), 32'h1);
        m0_req = 0;
        step();
        step();
        chk_eq("drop ack", 32'({m1_ack, m0_ack}), 32'h1);
        chk_eq("drop rdata", 32'(m0_rdata), 32'h7777);
        begin
            logic [3:0] seen;
            seen = '0;
            for (int k = 0; k < 5; k++) begin
                step();
                seen = seen | {grant, ip_rd_ce, m0_ack};
            end
            chk_eq("drop no re-access", 32'(seen), 32'h0);
        end

        // Locking: m1 holds lock for three transfers while m0 keeps requesting
`ifdef IPBUS_ARB_LOCK_EN
        lock_seq = '{2'b10, 2'b10, 2'b10, 2'b01};
`else
        lock_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
        m0_req = 1; m1_req = 1; m1_lock = 1;
        for (int i = 0; i < 4; i++) begin
            xfer($sformatf("lock%0d", i), lock_seq[i],
                 lock_seq[i][1] ? 16'h0200 : 16'h0100, 16'hC000 + 16'(i));
            if (i == 2) m1_lock = 0;
        end
        m0_req = 0; m1_req = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
